mux5_rr_sched: RTL
==================

# mux5_rr_sched

Round-robin scheduler that shares a 5:1 multiplexer datapath between five requesters. Each requester raises `req` with its data. The block picks one requester fairly and drives the 3-bit mux select in the team's 5x1 mux encoding. It captures the selected data into a registered output stage and returns a per-requester acknowledge when the downstream consumer accepts the beat. It sits between five independent producers and a single shared downstream port.

## Interface
- `DATA_W`, default 8: width of each requester's data word.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  5  request per requester; bit n belongs to requester n.
- `din`  in  5*DATA_W  packed data; requester n owns `din[n*DATA_W +: DATA_W]`.
- `ack`  out  5  one-hot pulse, asserted in the cycle requester n's beat is accepted.
- `gnt`  out  5  one-hot registered grant; all zero when idle.
- `sel`  out  3  registered binary index of the granted requester (0..4), for the 5:1 mux select.
- `out_valid`  out  1  output beat valid.
- `out_data`  out  DATA_W  registered data of the granted requester.
- `out_ready`  in  1  downstream accepts the beat when high together with `out_valid`.

## Operation
- **State machine:** two states, IDLE and BUSY.
  - IDLE holds `out_valid`=0 and `gnt`=0.
  - BUSY holds `out_valid`=1.
- **Round-robin pointer:**
  - 3-bit register `ptr`, range 0..4; this is the highest-priority index.
  - Search order is `ptr`, `ptr+1`, …, wrapping 4→0.
  - After a transfer from index k, `ptr` becomes k+1 mod 5, so 4 wraps to 0.
  - Values 5..7 never appear in `ptr` or `sel`.
- **IDLE:** if `req`≠0, register the winner.
  - Set `gnt` to the winner's one-hot bit and `sel` to its index.
  - Set `out_data` to the winner's `din` slice and `out_valid` to 1.
  - Go to BUSY. If `req`=0, stay in IDLE.
- **BUSY, no handshake** (`out_ready`=0):
  - Hold `gnt`, `sel` and `out_data` stable.
  - New requests are ignored; there is no preemption.
- **BUSY, handshake** (`out_valid`&&`out_ready`):
  - `ack` = `gnt` in this cycle, combinational.
  - `ptr` is updated.
  - Re-arbitrate in the same cycle over `req & ~gnt`, searching from the updated `ptr`.
    - If any requester wins, load the new grant, `sel` and data, and stay in BUSY. This gives back-to-back transfers.
    - Otherwise clear `gnt` and `out_valid` and go to IDLE.
- **Data capture:** data is captured at grant time. If a requester drops `req` while granted, the captured beat still completes and `ack` is still issued.
- **Requester protocol:** a requester holds `req` and `din` until its `ack`. It may re-request in the cycle after `ack`.
- **`ack`:** never more than one bit high; zero whenever no handshake occurs.

## Timing
- **Reset values** (from `rst`=1 at a clock edge): state IDLE, `ptr`=0, `gnt`=0, `sel`=0, `out_valid`=0, `out_data`=0, `ack`=0.
- **Reset priority:** reset overrides everything. A transfer in flight is abandoned and no `ack` is issued.
- **Latency:** `req` rising in cycle t (block in IDLE) gives `out_valid`=1 in cycle t+1.
- **Throughput:** with continuous `out_ready`=1 and pending requests, one beat per cycle.
- **Output registers:** `gnt`, `sel`, `out_valid` and `out_data` are registered.
- **Combinational outputs:** `ack` is combinational from `gnt`, `out_valid` and `out_ready`.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `req`=5'b11111.
  - `out_valid`, `gnt`, `sel`, `out_data` and `ack` are all 0 during reset.
  - First grant after release is index 0.
- **Single requester:** `req`=5'b00100, `din` slice 2 = 8'hA5, `out_ready`=1.
  - Next cycle: `out_valid`=1, `sel`=2, `gnt`=5'b00100, `out_data`=8'hA5, `ack`=5'b00100.
  - Then `ptr`=3.
- **Fairness:** `req`=5'b11111 held, `out_ready`=1 held.
  - `sel` sequence is 0,1,2,3,4,0,1 on consecutive cycles.
  - `ack` follows the same order, one bit per cycle.
- **Backpressure:** grant index 1, then hold `out_ready`=0 for 3 cycles while `req` changes to 5'b11101 and `din` changes.
  - `sel`=1, `out_data` and `gnt` stay stable; `ack`=0.
  - Raising `out_ready` gives `ack`=5'b00010, then the next grant is index 2.
- **Wrap-around:** after a transfer from index 4 (`ptr`=0), apply `req`=5'b10001.
  - Grant 0 first, then 4.
- **Mid-transfer reset and idle return:**
  - Reset asserted while BUSY with `out_ready`=0: no `ack`, all outputs 0 next cycle.
  - Separately, a handshake with `req`=0 returns to IDLE with `out_valid`=0 in the next cycle.

Source files
------------

// File: rtl/mux5_rr_sched.sv
// Round-robin scheduler sharing one 5:1 mux datapath between five requesters.
// The grant, mux select and captured data are registered; ack is combinational.
module mux5_rr_sched #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          req,
    input  logic [5*DATA_W-1:0] din,
    output logic [4:0]          ack,
    output logic [4:0]          gnt,
    output logic [2:0]          sel,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic                out_ready,
    output logic                dbg_state,
    output logic [2:0]          dbg_ptr
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state;
    logic [2:0]        ptr;
    logic              hs;
    logic [2:0]        ptr_next;
    logic [2:0]        base;
    logic [4:0]        cand;
    logic [3:0]        idx;
    logic              win_found;
    logic [2:0]        win_idx;
    logic [DATA_W-1:0] win_data;

    // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
    // out_valid stays high and gnt/sel/out_data stay frozen until that happens.
    assign hs        = out_valid && out_ready;
    assign ack       = (hs && !rst) ? gnt : 5'b0;
    assign dbg_state = state;
    assign dbg_ptr   = ptr;

    // After a transfer, priority moves to the index just past the one served.
    assign ptr_next = (sel == 3'd4) ? 3'd0 : sel + 3'd1;
    assign base     = (state == BUSY) ? ptr_next : ptr;
    assign cand     = (state == BUSY) ? (req & ~gnt) : req;

    // Walk downward so the closest index to base (i = 0) is the final winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        idx       = 4'd0;
        for (int i = 4; i >= 0; i--) begin
            idx = {1'b0, base} + 4'(i);
            if (idx >= 4'd5)
                idx = idx - 4'd5;
            if (cand[idx[2:0]]) begin
                win_found = 1'b1;
                win_idx   = idx[2:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int n = 0; n < 5; n++) begin
            if (win_idx == 3'(n))
                win_data = din[n*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            gnt       <= 5'b0;
            sel       <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt       <= 5'b00001 << win_idx;
                        sel       <= win_idx;
                        out_data  <= win_data;
                        out_valid <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (hs) begin
                        ptr <= ptr_next;
                        if (win_found) begin
                            gnt      <= 5'b00001 << win_idx;
                            sel      <= win_idx;
                            out_data <= win_data;
                        end else begin
                            gnt       <= 5'b0;
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
